// File: rtl/siphash_core_pkg.sv
// Shared constants, state encoding and small helpers for the SipHash engine.
package siphash_core_pkg;

  localparam logic [63:0] IV0     = 64'h736f6d6570736575;
  localparam logic [63:0] IV1     = 64'h646f72616e646f6d;
  localparam logic [63:0] IV2     = 64'h6c7967656e657261;
  localparam logic [63:0] IV3     = 64'h7465646279746573;
  localparam logic [63:0] FIN_XOR = 64'h00000000000000ff;

  localparam int DEF_C_ROUNDS = 2;
  localparam int DEF_D_ROUNDS = 4;

  typedef enum logic [2:0] {IDLE, WAIT, COMPRESS, FINAL, DONE} state_t;

  // Ones in the low `len` bytes; the top byte is never set since len <= 7.
  function automatic logic [63:0] byte_mask(input logic [2:0] len);
    logic [63:0] mask;
    mask = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < int'(len)) mask[8*i +: 8] = 8'hff;
    end
    return mask;
  endfunction

  function automatic logic [63:0] rotl(input logic [63:0] x, input int n);
    return (x << n) | (x >> (64 - n));
  endfunction

endpackage

// File: rtl/siphash_core_if.sv
// Word-in / tag-out handshake bundle of the SipHash engine.
interface siphash_core_if;
  logic [127:0] key;
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  in_data;
  logic         in_last;
  logic [2:0]   in_len;
  logic         out_valid;
  logic         out_ready;
  logic [63:0]  out_hash;

  modport master (
    output key, in_valid, in_data, in_last, in_len, out_ready,
    input  in_ready, out_valid, out_hash
  );

  modport slave (
    input  key, in_valid, in_data, in_last, in_len, out_ready,
    output in_ready, out_valid, out_hash
  );
endinterface

// File: rtl/siphash_core_sip_round.sv
// One combinational SipRound (ARX network) over the four state words.
module sip_round
  import siphash_core_pkg::*;
(
  input  logic [63:0] v0_i,
  input  logic [63:0] v1_i,
  input  logic [63:0] v2_i,
  input  logic [63:0] v3_i,
  output logic [63:0] v0_o,
  output logic [63:0] v1_o,
  output logic [63:0] v2_o,
  output logic [63:0] v3_o
);

  logic [63:0] a, b, c, d;

  always_comb begin
    a = v0_i + v1_i;
    b = rotl(v1_i, 13) ^ a;
    a = rotl(a, 32);
    c = v2_i + v3_i;
    d = rotl(v3_i, 16) ^ c;
    a = a + d;
    d = rotl(d, 21) ^ a;
    c = c + b;
    b = rotl(b, 17) ^ c;
    c = rotl(c, 32);
    v0_o = a;
    v1_o = b;
    v2_o = c;
    v3_o = d;
  end

endmodule

// File: rtl/siphash_core.sv
// Sequential SipHash-c-d engine: absorbs 64-bit LE words, one SipRound per
// cycle for compression and finalization, then presents the 64-bit tag.
module siphash_core
  import siphash_core_pkg::*;
#(
  parameter int C_ROUNDS = DEF_C_ROUNDS,
  parameter int D_ROUNDS = DEF_D_ROUNDS
) (
  input  logic           clk,
  input  logic           rst_n,
  siphash_core_if.slave  bus
);

  state_t      state_q, state_d;
  logic [63:0] v0_q, v1_q, v2_q, v3_q, v0_d, v1_d, v2_d, v3_d;
  logic [63:0] m_q, m_d;
  logic        last_q, last_d;
  logic [7:0]  rcnt_q, rcnt_d;
  logic [7:0]  len_q, len_d;
  logic [63:0] out_hash_q, out_hash_d;
  logic        out_valid_q, out_valid_d;

  logic [63:0] r0, r1, r2, r3;
  logic [63:0] word_m, k0, k1;
  logic        in_ready, hs;

  sip_round u_round (
    .v0_i(v0_q), .v1_i(v1_q), .v2_i(v2_q), .v3_i(v3_q),
    .v0_o(r0),   .v1_o(r1),   .v2_o(r2),   .v3_o(r3)
  );

  assign k0       = bus.key[63:0];
  assign k1       = bus.key[127:64];
  assign in_ready = rst_n && (state_q == IDLE || state_q == WAIT);
  assign hs       = bus.in_valid && in_ready;

  // Last word: length byte on top, payload trimmed to in_len bytes.
  assign word_m = bus.in_last
                ? ({len_q + {5'b0, bus.in_len}, 56'h0} | (bus.in_data & byte_mask(bus.in_len)))
                : bus.in_data;

  always_comb begin
    state_d     = state_q;
    v0_d        = v0_q;
    v1_d        = v1_q;
    v2_d        = v2_q;
    v3_d        = v3_q;
    m_d         = m_q;
    last_d      = last_q;
    rcnt_d      = rcnt_q;
    len_d       = len_q;
    out_hash_d  = out_hash_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE, WAIT: begin
        if (hs) begin
          if (state_q == IDLE) begin
            v0_d = k0 ^ IV0;
            v1_d = k1 ^ IV1;
            v2_d = k0 ^ IV2;
            v3_d = k1 ^ IV3 ^ word_m;
          end else begin
            v3_d = v3_q ^ word_m;
          end
          m_d     = word_m;
          last_d  = bus.in_last;
          len_d   = bus.in_last ? len_q : len_q + 8'd8;
          rcnt_d  = '0;
          state_d = COMPRESS;
        end
      end
      COMPRESS: begin
        v0_d   = r0;
        v1_d   = r1;
        v2_d   = r2;
        v3_d   = r3;
        rcnt_d = rcnt_q + 8'd1;
        if (rcnt_q == 8'(C_ROUNDS - 1)) begin
          v0_d   = r0 ^ m_q;
          rcnt_d = '0;
          if (last_q) begin
            v2_d    = r2 ^ FIN_XOR;
            state_d = FINAL;
          end else begin
            state_d = WAIT;
          end
        end
      end
      FINAL: begin
        // D_ROUNDS round cycles, then one cycle to fold the state into the tag.
        if (rcnt_q == 8'(D_ROUNDS)) begin
          out_hash_d  = v0_q ^ v1_q ^ v2_q ^ v3_q;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          v0_d   = r0;
          v1_d   = r1;
          v2_d   = r2;
          v3_d   = r3;
          rcnt_d = rcnt_q + 8'd1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          len_d       = '0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      v0_q        <= '0;
      v1_q        <= '0;
      v2_q        <= '0;
      v3_q        <= '0;
      m_q         <= '0;
      last_q      <= 1'b0;
      rcnt_q      <= '0;
      len_q       <= '0;
      out_hash_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      v0_q        <= v0_d;
      v1_q        <= v1_d;
      v2_q        <= v2_d;
      v3_q        <= v3_d;
      m_q         <= m_d;
      last_q      <= last_d;
      rcnt_q      <= rcnt_d;
      len_q       <= len_d;
      out_hash_q  <= out_hash_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_hash  = out_hash_q;

endmodule

// File: tb/tb_siphash_core.sv
// Self-checking bench for siphash_core: known vectors, backpressure, stalls,
// mid-hash reset and random messages against a byte-level SipHash-2-4 model.
module tb_siphash_core;

  typedef logic [7:0]       bq_t[$];
  typedef logic [3:0][63:0] st_t;

  localparam int           CR    = 2;
  localparam int           DR    = 4;
  localparam logic [127:0] VKEY  = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [63:0]  H_EMP = 64'h726fdb47dd0e0e31;
  localparam logic [63:0]  H_15  = 64'ha129ca6149be45e5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  siphash_core_if bus();

  siphash_core #(.C_ROUNDS(CR), .D_ROUNDS(DR)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int total = 0;
  int bad = 0;
  int hs_cnt = 0;

  always @(posedge clk) if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) hs_cnt++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference SipHash-2-4 built directly from the algorithm definition.
  function automatic logic [63:0] rol(input logic [63:0] x, input int s);
    logic [127:0] t;
    t = {x, x};
    t = t >> (64 - s);
    return t[63:0];
  endfunction

  function automatic st_t sr(input st_t v);
    v[0] += v[1]; v[1] = rol(v[1], 13) ^ v[0]; v[0] = rol(v[0], 32);
    v[2] += v[3]; v[3] = rol(v[3], 16) ^ v[2];
    v[0] += v[3]; v[3] = rol(v[3], 21) ^ v[0];
    v[2] += v[1]; v[1] = rol(v[1], 17) ^ v[2]; v[2] = rol(v[2], 32);
    return v;
  endfunction

  function automatic logic [63:0] ref_hash(input logic [127:0] k, input bq_t msg);
    st_t v;
    logic [63:0] m;
    int n, nb;
    n = msg.size();
    nb = n / 8;
    v[0] = k[63:0]   ^ 64'h736f6d6570736575;
    v[1] = k[127:64] ^ 64'h646f72616e646f6d;
    v[2] = k[63:0]   ^ 64'h6c7967656e657261;
    v[3] = k[127:64] ^ 64'h7465646279746573;
    for (int w = 0; w <= nb; w++) begin
      m = '0;
      if (w < nb) begin
        for (int b = 0; b < 8; b++) m |= 64'(msg[8*w+b]) << (8*b);
      end else begin
        for (int b = 0; b < n % 8; b++) m |= 64'(msg[8*w+b]) << (8*b);
        m[63:56] = 8'(n % 256);
      end
      v[3] ^= m;
      for (int r = 0; r < CR; r++) v = sr(v);
      v[0] ^= m;
    end
    v[2] ^= 64'hff;
    for (int r = 0; r < DR; r++) v = sr(v);
    return v[0] ^ v[1] ^ v[2] ^ v[3];
  endfunction

  // Drives one message; unused high bytes of the last word take `fill`.
  task automatic send_msg(input logic [127:0] k, input bq_t msg, input int gap,
                          input logic [63:0] fill, input bit churn);
    int n, nb, h0, to;
    logic [63:0] d;
    n = msg.size();
    nb = n / 8;
    h0 = hs_cnt;
    bus.key = k;
    for (int w = 0; w <= nb; w++) begin
      d = fill;
      for (int b = 0; b < ((w < nb) ? 8 : n % 8); b++) d[8*b +: 8] = msg[8*w+b];
      bus.in_data  = d;
      bus.in_last  = (w == nb);
      bus.in_len   = 3'(n % 8);
      bus.in_valid = 1'b1;
      to = 0;
      @(negedge clk);
      while (bus.in_ready !== 1'b1 && to < 100) begin
        @(negedge clk);
        to++;
      end
      if (to >= 100) chk("hs_timeout", 64'd1, 64'd0);
      @(posedge clk);
      #1;
      if (churn) bus.key = {$urandom, $urandom, $urandom, $urandom};
      if (w < nb && gap > 0) begin
        bus.in_valid = 1'b0;
        bus.in_data  = {$urandom, $urandom};
        repeat (gap) @(posedge clk);
        #1;
      end
    end
    bus.in_valid = 1'b0;
    chk("hs_count", 64'(hs_cnt - h0), 64'(nb + 1));
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (bus.out_valid !== 1'b1) chk("out_timeout", 64'd0, 64'd1);
  endtask

  task automatic take_tag(input string tag, input logic [63:0] exp, input int hold);
    chk(tag, bus.out_hash, exp);
    repeat (hold) @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk({tag, "_clr"}, 64'(bus.out_valid), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t e, m15, rm;
    int lat, h0, viol, len;
    logic [127:0] rk;

    bus.key = '0; bus.in_valid = 1'b0; bus.in_data = '0;
    bus.in_last = 1'b0; bus.in_len = '0; bus.out_ready = 1'b0;
    for (int i = 0; i < 15; i++) m15.push_back(8'(i));

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_hash", bus.out_hash, 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_in_ready", 64'(bus.in_ready), 64'd1);

    send_msg(VKEY, e, 0, 64'd0, 1'b0);
    wait_out(lat);
    chk("empty_lat", 64'(lat), 64'd7);
    take_tag("empty", H_EMP, 0);

    send_msg(VKEY, m15, 0, 64'd0, 1'b0);
    wait_out(lat);
    take_tag("m15", H_15, 2);

    send_msg(VKEY, m15, 0, 64'hAAAAAAAAAAAAAAAA, 1'b0);
    wait_out(lat);
    take_tag("m15_mask", H_15, 0);

    // Tag held under backpressure while a new first word waits.
    send_msg(VKEY, m15, 0, 64'd0, 1'b0);
    wait_out(lat);
    bus.key = VKEY; bus.in_data = '0; bus.in_last = 1'b1; bus.in_len = '0;
    bus.in_valid = 1'b1;
    h0 = hs_cnt;
    viol = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (bus.out_hash !== H_15 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) viol++;
    end
    chk("bp_hold", 64'(viol), 64'd0);
    chk("bp_no_hs", 64'(hs_cnt - h0), 64'd0);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk("bp_released", 64'(bus.out_valid), 64'd0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("bp_accept", 64'(hs_cnt - h0), 64'd1);
    wait_out(lat);
    chk("bp_lat", 64'(lat), 64'd7);
    take_tag("bp_next", H_EMP, 0);

    send_msg(VKEY, m15, 5, 64'hAAAAAAAAAAAAAAAA, 1'b1);
    wait_out(lat);
    take_tag("stall", H_15, 0);

    // Reset during the second finalization round.
    send_msg(VKEY, e, 0, 64'd0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstf_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rstf_in_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rstf_idle", 64'(bus.in_ready), 64'd1);
    send_msg(VKEY, e, 0, 64'd0, 1'b0);
    wait_out(lat);
    take_tag("rstf_empty", H_EMP, 0);

    for (int r = 0; r < 14; r++) begin
      len = (r == 13) ? 300 : int'($urandom_range(0, 40));
      rk = {$urandom, $urandom, $urandom, $urandom};
      rm = {};
      for (int i = 0; i < len; i++) rm.push_back(8'($urandom));
      bus.out_ready = 1'($urandom_range(0, 1));
      send_msg(rk, rm, int'($urandom_range(0, 3)), {$urandom, $urandom}, 1'b1);
      wait_out(lat);
      chk("rnd_lat", 64'(lat), 64'd7);
      take_tag("rnd", ref_hash(rk, rm), int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/siphash_core.md
Name: siphash_core

Overview:
- Sequential SipHash engine that absorbs a stream of 64-bit little-endian message words and produces the 64-bit tag.
- Holds the v0..v3 state registers and feeds them through one combinational sip_round instance per cycle, for both compression and finalization.
- Sits between the message-word packer upstream and the tag consumer downstream, with valid/ready on both sides.

Parameters:
- C_ROUNDS, 2, compression rounds per message word (>=1)
- D_ROUNDS, 4, finalization rounds (>=1)

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- key  input  128  k0=key[63:0], k1=key[127:64]; sampled on the first-word handshake of each message
- in_valid  input  1  message word valid
- in_ready  output  1  core accepts a word this cycle
- in_data  input  64  message word, byte 0 in [7:0]
- in_last  input  1  word is the final block of the message
- in_len  input  3  valid low bytes of the last word (0..7); ignored when in_last=0
- out_valid  output  1  tag valid
- out_ready  input  1  consumer takes the tag
- out_hash  output  64  tag = v0^v1^v2^v3

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous, active-low (rst_n).
- Reset values:
  - state=IDLE, in_ready=0 while rst_n low, out_valid=0, out_hash=0.
  - v0..v3, round counter, length byte and message register all 0.
- Message framing:
  - Every non-last word carries 8 bytes.
  - Every message ends with exactly one word with in_last=1 carrying in_len bytes (0..7). A 16-byte message is two full words plus a last word with in_len=0.
- Final block: m = {len_byte, in_data masked to in_len low bytes, upper bytes zeroed}.
  - len_byte = (8*full_words + in_len) mod 256, from an 8-bit wrapping counter.
- States:
  - IDLE: in_ready=1. On handshake:
    - v0=k0^736f6d6570736575, v1=k1^646f72616e646f6d, v2=k0^6c7967656e657261, v3=k1^7465646279746573^m.
    - Latch m and last flag; go COMPRESS, rcnt=0.
  - WAIT: in_ready=1. On handshake: v3^=m, latch m and last; go COMPRESS.
  - COMPRESS: in_ready=0. One sip_round per cycle, rcnt++.
    - On round C_ROUNDS, the registered value is round_out with v0^=m.
    - If last, additionally v2^=0x00000000000000ff; go FINAL, rcnt=0.
    - Otherwise go WAIT.
  - FINAL: one round per cycle. On round D_ROUNDS, out_hash<=xor of round outputs, out_valid<=1, go DONE.
  - DONE: out_valid=1, out_hash stable, in_ready=0. On out_ready, out_valid<=0, length counter cleared, go IDLE.
- Latency: the last-word handshake at edge t gives out_valid high after edge t+C_ROUNDS+D_ROUNDS+1. For 2-4 that is 7 cycles.
- Throughput: one non-last word per C_ROUNDS+1 cycles.
- Boundary conditions:
  - in_valid while busy: held off by in_ready=0; data is not sampled.
  - out_ready held low: DONE persists indefinitely and no new message is accepted.
  - out_ready asserted before out_valid: no effect.
  - Key changes mid-message: ignored until the next IDLE handshake.
  - Length above 255 bytes: len_byte wraps mod 256.
  - rst_n low at any cycle: immediate return to reset values and the partial message is discarded.
  - No handshake occurs while rst_n is low.

Decomposition:
- siphash_pkg holds:
  - the four IV constants;
  - the 0xff finalization constant;
  - default round counts;
  - state enum {IDLE, WAIT, COMPRESS, FINAL, DONE};
  - a byte-mask function of in_len.
- Single sub-module: the existing sip_round, one instance driven from the v registers.
- The FSM, counters and datapath muxing live in siphash_core.

Test Plan:
- Empty message: key=0x0f0e0d0c0b0a09080706050403020100; one word in_last=1, in_len=0, in_data=0 -> out_hash=0x726fdb47dd0e0e31, out_valid exactly 7 cycles after the handshake.
- 15-byte message 00..0e, same key: word 0x0706050403020100, then last word 0x000e0d0c0b0a0908 with in_len=7 -> out_hash=0xa129ca6149be45e5.
- Masking: repeat the 15-byte case with in_data[63:56]=0xAA on the last word -> identical hash 0xa129ca6149be45e5.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid -> out_hash stable, in_ready=0 throughout, and a pending in_valid is not consumed. Then pulse out_ready -> IDLE, the next message is accepted and hashes correctly.
- Input stall: insert 5 idle cycles between words of the 15-byte case, and drive in_valid during COMPRESS -> no extra handshakes, same hash.
- Reset mid-FINAL: assert rst_n low during FINAL round 2 -> out_valid=0 and state IDLE asynchronously. A fresh empty message then yields 0x726fdb47dd0e0e31.
